// File: rtl/act_mem_layer_scheduler.sv
// Ping-pong activation memory sequencer: assigns source/destination banks per
// layer, swaps them on layer_done, gates host access and watches each layer.
module act_mem_layer_scheduler #(
  parameter int ADDR_W    = 12,
  parameter int N_DIM_LOG = 4,
  parameter int LAYER_W   = 6,
  parameter int TMO_W     = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [LAYER_W-1:0] cfg_num_layers,
  input  logic               cfg_first_bank,
  input  logic [ADDR_W-2:0]  cfg_in_base,
  input  logic [ADDR_W-2:0]  cfg_out_base,
  input  logic [TMO_W-1:0]   cfg_timeout,
  input  logic               layer_done,
  output logic               layer_start,
  output logic [ADDR_W-1:0]  input_memory_pointer,
  output logic [ADDR_W-1:0]  output_memory_pointer,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               busy,
  output logic               done,
  output logic               result_bank,
  input  logic               ext_req,
  output logic               ext_gnt,
  output logic               tmo_err,
  output logic               proto_err
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_SWAP  = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  // Pointers always address whole rows, so the in-row bits are cleared.
  localparam logic [ADDR_W-2:0] ROW_MASK = ~((ADDR_W-1)'((32'd1 << N_DIM_LOG) - 32'd1));

  logic [2:0]         state_r;
  logic [2:0]         state_nxt_s;
  logic [LAYER_W-1:0] num_layers_r;
  logic               first_bank_r;
  logic [ADDR_W-2:0]  in_base_r;
  logic [ADDR_W-2:0]  out_base_r;
  logic [TMO_W-1:0]   timeout_r;
  logic [TMO_W-1:0]   wdog_r;
  logic               start_ok_s;
  logic               abort_act_s;
  logic               last_layer_s;
  logic               tmo_hit_s;
  logic               tmo_fire_s;
  logic               proto_hit_s;

  assign start_ok_s   = start && !abort && (state_r == ST_IDLE);
  assign abort_act_s  = abort && (state_r != ST_IDLE);
  assign last_layer_s = (layer_idx == (num_layers_r - LAYER_W'(1)));
  assign tmo_hit_s    = (timeout_r != {TMO_W{1'b0}}) && (wdog_r == (timeout_r - TMO_W'(1)));
  assign tmo_fire_s   = (state_r == ST_RUN) && !abort && !layer_done && tmo_hit_s;
  assign proto_hit_s  = layer_done && (state_r != ST_RUN) && !abort_act_s;
  assign ext_gnt      = ext_req && (state_r == ST_IDLE);

  // Next-state selection; abort overrides everything once a run is active.
  always_comb begin
    state_nxt_s = state_r;
    if (abort_act_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_ok_s) state_nxt_s = ST_SETUP;
          else            state_nxt_s = ST_IDLE;
        end
        ST_SETUP: begin
          if (num_layers_r == {LAYER_W{1'b0}}) state_nxt_s = ST_FIN;
          else                                 state_nxt_s = ST_RUN;
        end
        ST_RUN: begin
          if (layer_done) begin
            if (last_layer_s) state_nxt_s = ST_FIN;
            else              state_nxt_s = ST_SWAP;
          end else if (tmo_hit_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_SWAP: state_nxt_s = ST_RUN;
        ST_FIN:  state_nxt_s = ST_IDLE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State register and the strobes derived from the upcoming state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      busy        <= 1'b0;
      layer_start <= 1'b0;
      done        <= 1'b0;
      wdog_r      <= {TMO_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      busy        <= (state_nxt_s != ST_IDLE);
      layer_start <= (state_nxt_s == ST_RUN) && (state_r != ST_RUN);
      done        <= (state_nxt_s == ST_FIN);
      wdog_r      <= (state_r == ST_RUN) ? (wdog_r + TMO_W'(1)) : {TMO_W{1'b0}};
    end
  end

  // Run configuration capture and sticky error flags (a set beats the start clear).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_layers_r <= {LAYER_W{1'b0}};
      first_bank_r <= 1'b0;
      in_base_r    <= {(ADDR_W-1){1'b0}};
      out_base_r   <= {(ADDR_W-1){1'b0}};
      timeout_r    <= {TMO_W{1'b0}};
      tmo_err      <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      if (start_ok_s) begin
        num_layers_r <= cfg_num_layers;
        first_bank_r <= cfg_first_bank;
        in_base_r    <= cfg_in_base;
        out_base_r   <= cfg_out_base;
        timeout_r    <= cfg_timeout;
        tmo_err      <= 1'b0;
        proto_err    <= 1'b0;
      end
      if (tmo_fire_s)  tmo_err   <= 1'b1;
      if (proto_hit_s) proto_err <= 1'b1;
    end
  end

  // Bank pointers, layer index and final bank; all held across abort and timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      input_memory_pointer  <= {ADDR_W{1'b0}};
      output_memory_pointer <= {ADDR_W{1'b0}};
      layer_idx             <= {LAYER_W{1'b0}};
      result_bank           <= 1'b0;
    end else begin
      case (state_r)
        ST_SETUP: begin
          if (!abort) begin
            input_memory_pointer  <= {first_bank_r, in_base_r & ROW_MASK};
            output_memory_pointer <= {~first_bank_r, out_base_r & ROW_MASK};
            layer_idx             <= {LAYER_W{1'b0}};
            if (num_layers_r == {LAYER_W{1'b0}}) result_bank <= first_bank_r;
          end
        end
        ST_SWAP: begin
          if (!abort) begin
            input_memory_pointer  <= output_memory_pointer;
            output_memory_pointer <= input_memory_pointer;
            layer_idx             <= layer_idx + LAYER_W'(1);
          end
        end
        ST_RUN: begin
          if (!abort && layer_done && last_layer_s) result_bank <= output_memory_pointer[ADDR_W-1];
        end
        default: begin
        end
      endcase
    end
  end

endmodule
